i2c_cfg_seq: RTL and testbench

I2C_CFG_SEQ -- requirements
Module: i2c_cfg_seq

---
 rtl/i2c_cfg_seq.sv | 228 ++++++++++++++++++++++
 tb/tb_i2c_cfg_seq.sv | 446 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_cfg_seq.sv
// Command-table sequencer: replays a table of I2C write/read requests into
// a simple I2C master handshake (vin/busy/vout), captures read payloads and
// aborts a sequence when one transaction exceeds the TIMEOUT budget.
module i2c_cfg_seq #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned BYTES_W = 3,
  parameter int unsigned BYTES_R = 3,
  parameter int unsigned GAP     = 8,
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       tbl_we,
  input  logic [$clog2(DEPTH)-1:0]   tbl_idx,
  input  logic [6:0]                 tbl_ain,
  input  logic                       tbl_opcode,
  input  logic [BYTES_W*8-1:0]       tbl_din,
  input  logic                       start,
  input  logic [$clog2(DEPTH):0]     cnt,
  output logic [6:0]                 ain,
  output logic [BYTES_W*8-1:0]       din,
  output logic                       opcode,
  output logic                       vin,
  input  logic [BYTES_R*8-1:0]       dout,
  input  logic                       vout,
  input  logic                       busy,
  output logic [BYTES_R*8-1:0]       rd_data,
  output logic [$clog2(DEPTH)-1:0]   rd_idx,
  output logic                       rd_valid,
  output logic                       running,
  output logic                       done,
  output logic                       err
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = IDX_W + 1;
  localparam int unsigned DW    = BYTES_W * 8;
  localparam int unsigned RW    = BYTES_R * 8;
  localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);
  localparam int unsigned GAP_W = $clog2(GAP + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_ISSUE,
    ST_WAIT_ACK,
    ST_WAIT_DONE,
    ST_GAP,
    ST_FIN
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [6:0]         ain_q, ain_d;
  logic [DW-1:0]      din_q, din_d;
  logic               opcode_q, opcode_d;
  logic               vin_q, vin_d;
  logic [RW-1:0]      rd_data_q, rd_data_d;
  logic [IDX_W-1:0]   rd_idx_q, rd_idx_d;
  logic               rd_valid_q, rd_valid_d;
  logic               running_q, running_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               tmr_hit;

  logic [6:0]         tbl_ain_q [DEPTH];
  logic               tbl_op_q  [DEPTH];
  logic [DW-1:0]      tbl_din_q [DEPTH];

  // Command table storage; frozen while a sequence runs, never reset.
  always_ff @(posedge clk) begin
    if (tbl_we && !running_q) begin
      tbl_ain_q[tbl_idx] <= tbl_ain;
      tbl_op_q[tbl_idx]  <= tbl_opcode;
      tbl_din_q[tbl_idx] <= tbl_din;
    end
  end

  // Next-state and registered-output logic for the sequencer.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    gap_d      = gap_q;
    tmr_d      = tmr_q;
    ain_d      = ain_q;
    din_d      = din_q;
    opcode_d   = opcode_q;
    rd_data_d  = rd_data_q;
    rd_idx_d   = rd_idx_q;
    err_d      = err_q;
    vin_d      = 1'b0;
    rd_valid_d = 1'b0;
    done_d     = 1'b0;
    tmr_hit    = (tmr_q == TMR_W'(TIMEOUT - 1));

    // Read data may arrive anywhere between the request and busy falling.
    if ((state_q == ST_WAIT_ACK || state_q == ST_WAIT_DONE) && vout && opcode_q) begin
      rd_data_d  = dout;
      rd_idx_d   = idx_q;
      rd_valid_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          err_d = 1'b0;
          if (cnt == '0) begin
            state_d = ST_FIN;
          end else begin
            cnt_d   = cnt;
            idx_d   = '0;
            state_d = ST_FETCH;
          end
        end
      end
      ST_FETCH: begin
        ain_d    = tbl_ain_q[idx_q];
        din_d    = tbl_din_q[idx_q];
        opcode_d = tbl_op_q[idx_q];
        tmr_d    = '0;
        state_d  = ST_ISSUE;
      end
      ST_ISSUE: begin
        tmr_d = tmr_q + TMR_W'(1);
        if (tmr_hit) begin
          err_d   = 1'b1;
          state_d = ST_FIN;
        end else if (!busy) begin
          vin_d   = 1'b1;
          state_d = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        tmr_d = tmr_q + TMR_W'(1);
        if (tmr_hit) begin
          err_d   = 1'b1;
          state_d = ST_FIN;
        end else if (busy) begin
          state_d = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        tmr_d = tmr_q + TMR_W'(1);
        if (tmr_hit) begin
          err_d   = 1'b1;
          state_d = ST_FIN;
        end else if (!busy) begin
          gap_d   = '0;
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_W'(GAP - 1)) begin
          if ((CNT_W'(idx_q) + CNT_W'(1)) < cnt_q) begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = ST_FETCH;
          end else begin
            state_d = ST_FIN;
          end
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      ST_FIN: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    running_d = (state_d != ST_IDLE);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      gap_q      <= '0;
      tmr_q      <= '0;
      ain_q      <= '0;
      din_q      <= '0;
      opcode_q   <= 1'b0;
      vin_q      <= 1'b0;
      rd_data_q  <= '0;
      rd_idx_q   <= '0;
      rd_valid_q <= 1'b0;
      running_q  <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      gap_q      <= gap_d;
      tmr_q      <= tmr_d;
      ain_q      <= ain_d;
      din_q      <= din_d;
      opcode_q   <= opcode_d;
      vin_q      <= vin_d;
      rd_data_q  <= rd_data_d;
      rd_idx_q   <= rd_idx_d;
      rd_valid_q <= rd_valid_d;
      running_q  <= running_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign ain      = ain_q;
  assign din      = din_q;
  assign opcode   = opcode_q;
  assign vin      = vin_q;
  assign rd_data  = rd_data_q;
  assign rd_idx   = rd_idx_q;
  assign rd_valid = rd_valid_q;
  assign running  = running_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_i2c_cfg_seq.sv
// Bench for i2c_cfg_seq: a behavioural I2C master answers requests, a
// monitor logs vin/rd_valid/done events, and each test compares the log
// against what the command table and the master's replies imply.
`timescale 1ns/1ps
module tb_i2c_cfg_seq;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned GAPC  = 8;
  localparam int unsigned IW    = 4;
  localparam int unsigned CW    = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tbl_we = 1'b0;
  logic [3:0]  tbl_idx = '0;
  logic [6:0]  tbl_ain = '0;
  logic        tbl_opcode = 1'b0;
  logic [23:0] tbl_din = '0;
  logic        start = 1'b0, start_t = 1'b0;
  logic [4:0]  cnt = '0, cnt_t = '0;
  logic        busy = 1'b0, busy_t = 1'b0;
  logic        vout = 1'b0, vout_t = 1'b0;
  logic [23:0] dout = '0, dout_t = '0;

  logic [6:0]  ain, ain_t;
  logic [23:0] din, din_t, rd_data, rd_data_t;
  logic        opcode, opcode_t, vin, vin_t, rd_valid, rd_valid_t;
  logic [3:0]  rd_idx, rd_idx_t;
  logic        running, running_t, done, done_t, err, err_t;

  always #5 clk = ~clk;

  i2c_cfg_seq #(.DEPTH(DEPTH), .BYTES_W(3), .BYTES_R(3), .GAP(GAPC), .TIMEOUT(1000)) dut (
    .clk(clk), .rst(rst), .tbl_we(tbl_we), .tbl_idx(tbl_idx), .tbl_ain(tbl_ain),
    .tbl_opcode(tbl_opcode), .tbl_din(tbl_din), .start(start), .cnt(cnt),
    .ain(ain), .din(din), .opcode(opcode), .vin(vin), .dout(dout), .vout(vout),
    .busy(busy), .rd_data(rd_data), .rd_idx(rd_idx), .rd_valid(rd_valid),
    .running(running), .done(done), .err(err));

  i2c_cfg_seq #(.DEPTH(DEPTH), .BYTES_W(3), .BYTES_R(3), .GAP(GAPC), .TIMEOUT(50)) dut_to (
    .clk(clk), .rst(rst), .tbl_we(tbl_we), .tbl_idx(tbl_idx), .tbl_ain(tbl_ain),
    .tbl_opcode(tbl_opcode), .tbl_din(tbl_din), .start(start_t), .cnt(cnt_t),
    .ain(ain_t), .din(din_t), .opcode(opcode_t), .vin(vin_t), .dout(dout_t), .vout(vout_t),
    .busy(busy_t), .rd_data(rd_data_t), .rd_idx(rd_idx_t), .rd_valid(rd_valid_t),
    .running(running_t), .done(done_t), .err(err_t));

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  // Expected table contents as the bench believes them to be.
  logic [6:0]  sh_ain [DEPTH];
  logic        sh_op  [DEPTH];
  logic [23:0] sh_din [DEPTH];

  // Event logs and the read replies the master handed out.
  int          ev_vin_cyc[$];
  logic [6:0]  ev_vin_ain[$];
  logic [23:0] ev_vin_din[$];
  logic        ev_vin_op[$];
  logic [23:0] ev_rd_data[$];
  int          ev_rd_idx[$];
  int          ev_done_cyc[$];
  int          ev_fall_cyc[$];
  logic [23:0] exp_rd_data[$];
  int          exp_rd_idx[$];

  // Master model knobs.
  bit          m_force = 1'b0;
  int          m_hold = 4;
  bit          m_early = 1'b0;
  bit          m_spur = 1'b0;
  bit          m_fix = 1'b0;
  logic [23:0] m_fix_val = '0;
  int          m_left = 0;
  int          m_vin_n = 0;
  int          m_cur_idx = 0;
  bit          m_cur_rd = 1'b0;

  always @(posedge clk) cyc++;

  // Behavioural I2C master: busy for m_hold cycles after each request,
  // read data offered one cycle before or exactly as busy falls.
  always @(negedge clk) begin
    logic [23:0] d;
    vout = 1'b0;
    if (rst) begin
      m_left = 0;
    end else if (m_left > 0) begin
      m_left = m_left - 1;
      if ((m_early && m_left == 1) || (!m_early && m_left == 0)) begin
        if (m_cur_rd || m_spur) begin
          d = m_fix ? m_fix_val : 24'($urandom);
          dout = d;
          vout = 1'b1;
          if (m_cur_rd) begin
            exp_rd_data.push_back(d);
            exp_rd_idx.push_back(m_cur_idx);
          end
        end
      end
      if (m_left == 0) ev_fall_cyc.push_back(cyc);
    end else if (vin) begin
      m_cur_idx = m_vin_n;
      m_cur_rd  = sh_op[m_vin_n % DEPTH];
      m_vin_n++;
      m_left = m_hold;
    end
    busy = m_force || (m_left > 0);
  end

  // Output monitor for the main instance.
  always @(negedge clk) begin
    if (vin) begin
      ev_vin_cyc.push_back(cyc);
      ev_vin_ain.push_back(ain);
      ev_vin_din.push_back(din);
      ev_vin_op.push_back(opcode);
    end
    if (rd_valid) begin
      ev_rd_data.push_back(rd_data);
      ev_rd_idx.push_back(int'(rd_idx));
    end
    if (done) ev_done_cyc.push_back(cyc);
  end

  task automatic clear_logs();
    ev_vin_cyc.delete(); ev_vin_ain.delete(); ev_vin_din.delete(); ev_vin_op.delete();
    ev_rd_data.delete(); ev_rd_idx.delete(); ev_done_cyc.delete(); ev_fall_cyc.delete();
    exp_rd_data.delete(); exp_rd_idx.delete();
    m_vin_n = 0;
  endtask

  task automatic tbl_write(input int idx, input logic [6:0] a, input logic op,
                           input logic [23:0] d, input bit shadow);
    @(negedge clk);
    tbl_we = 1'b1; tbl_idx = IW'(idx); tbl_ain = a; tbl_opcode = op; tbl_din = d;
    if (shadow) begin
      sh_ain[idx] = a; sh_op[idx] = op; sh_din[idx] = d;
    end
    @(negedge clk);
    tbl_we = 1'b0;
  endtask

  task automatic pulse_start(input int n, output int sc);
    @(negedge clk);
    clear_logs();
    start = 1'b1; cnt = CW'(n); sc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (ev_done_cyc.size() > 0) begin ok = 1'b1; break; end
    end
    n_chk++;
    if (!ok) $display("FAIL wait_done: no done within %0d cycles (required a done pulse)", budget);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({vin, rd_valid, done, running, err} !== 5'b0)
      $display("FAIL reset_flags: got %b required 00000", {vin, rd_valid, done, running, err});
    else n_pass++;
    n_chk++;
    if ({ain, din, opcode} !== 32'h0)
      $display("FAIL reset_req: got %h required 0", {ain, din, opcode});
    else n_pass++;
    n_chk++;
    if ({rd_data, rd_idx, err_t, running_t} !== 30'h0)
      $display("FAIL reset_rd: got %h required 0", {rd_data, rd_idx, err_t, running_t});
    else n_pass++;
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single();
    int sc; bit ok;
    tbl_write(0, 7'h41, 1'b0, 24'h05C5DD, 1'b1);
    m_hold = 100; m_early = 1'b0; m_spur = 1'b0; m_fix = 1'b0;
    pulse_start(1, sc);
    wait_done(400, ok);
    n_chk++;
    if (ev_vin_cyc.size() != 1) $display("FAIL single_vin_count: got %0d required 1", ev_vin_cyc.size());
    else n_pass++;
    if (ev_vin_cyc.size() > 0) begin
      n_chk++;
      if ({ev_vin_ain[0], ev_vin_din[0], ev_vin_op[0]} !== {7'h41, 24'h05C5DD, 1'b0})
        $display("FAIL single_req: got ain=%h din=%h op=%b required ain=41 din=05c5dd op=0",
                 ev_vin_ain[0], ev_vin_din[0], ev_vin_op[0]);
      else n_pass++;
    end
    if (ok && ev_fall_cyc.size() > 0) begin
      n_chk++;
      if (ev_done_cyc[0] - ev_fall_cyc[0] != int'(GAPC) + 2)
        $display("FAIL single_done_delay: got %0d required %0d", ev_done_cyc[0] - ev_fall_cyc[0], GAPC + 2);
      else n_pass++;
    end
    n_chk++;
    if (err !== 1'b0) $display("FAIL single_err: got %b required 0", err);
    else n_pass++;
  endtask

  task automatic test_wrw_read();
    int sc; bit ok;
    tbl_write(0, 7'($urandom), 1'b0, 24'($urandom), 1'b1);
    tbl_write(1, 7'($urandom), 1'b1, 24'($urandom), 1'b1);
    tbl_write(2, 7'($urandom), 1'b0, 24'($urandom), 1'b1);
    m_hold = $urandom_range(2, 12); m_early = 1'($urandom_range(0, 1));
    m_spur = 1'b0; m_fix = 1'b1; m_fix_val = 24'hABCDFF;
    pulse_start(3, sc);
    wait_done(600, ok);
    n_chk++;
    if (ev_vin_cyc.size() != 3) $display("FAIL wrw_vin_count: got %0d required 3", ev_vin_cyc.size());
    else n_pass++;
    for (int i = 0; i < ev_vin_cyc.size() && i < 3; i++) begin
      n_chk++;
      if ({ev_vin_ain[i], ev_vin_din[i], ev_vin_op[i]} !== {sh_ain[i], sh_din[i], sh_op[i]})
        $display("FAIL wrw_req%0d: got %h/%h/%b required %h/%h/%b", i, ev_vin_ain[i], ev_vin_din[i],
                 ev_vin_op[i], sh_ain[i], sh_din[i], sh_op[i]);
      else n_pass++;
      if (i > 0 && ev_fall_cyc.size() >= i) begin
        n_chk++;
        if (ev_vin_cyc[i] - ev_fall_cyc[i-1] != int'(GAPC) + 3)
          $display("FAIL wrw_spacing%0d: got %0d required %0d", i, ev_vin_cyc[i] - ev_fall_cyc[i-1], GAPC + 3);
        else n_pass++;
      end
    end
    n_chk++;
    if (ev_rd_data.size() != 1) $display("FAIL wrw_rd_count: got %0d required 1", ev_rd_data.size());
    else n_pass++;
    if (ev_rd_data.size() > 0) begin
      n_chk++;
      if (ev_rd_data[0] !== 24'hABCDFF || ev_rd_idx[0] != 1)
        $display("FAIL wrw_rd: got data=%h idx=%0d required data=abcdff idx=1", ev_rd_data[0], ev_rd_idx[0]);
      else n_pass++;
    end
    m_fix = 1'b0;
  endtask

  task automatic test_random();
    int sc, n; bit ok;
    for (int it = 0; it < 6; it++) begin
      n = $urandom_range(1, 5);
      for (int i = 0; i < n; i++) tbl_write(i, 7'($urandom), 1'($urandom), 24'($urandom), 1'b1);
      m_hold = $urandom_range(2, 12); m_early = 1'($urandom_range(0, 1));
      m_spur = 1'($urandom_range(0, 1));
      pulse_start(n, sc);
      wait_done(1500, ok);
      n_chk++;
      if (ev_vin_cyc.size() != n) $display("FAIL rand%0d_vin_count: got %0d required %0d", it, ev_vin_cyc.size(), n);
      else n_pass++;
      for (int i = 0; i < ev_vin_cyc.size() && i < n; i++) begin
        n_chk++;
        if ({ev_vin_ain[i], ev_vin_din[i], ev_vin_op[i]} !== {sh_ain[i], sh_din[i], sh_op[i]})
          $display("FAIL rand%0d_req%0d: got %h/%h/%b required %h/%h/%b", it, i, ev_vin_ain[i],
                   ev_vin_din[i], ev_vin_op[i], sh_ain[i], sh_din[i], sh_op[i]);
        else n_pass++;
      end
      n_chk++;
      if (ev_rd_data.size() != exp_rd_data.size())
        $display("FAIL rand%0d_rd_count: got %0d required %0d", it, ev_rd_data.size(), exp_rd_data.size());
      else n_pass++;
      for (int i = 0; i < ev_rd_data.size() && i < exp_rd_data.size(); i++) begin
        n_chk++;
        if (ev_rd_data[i] !== exp_rd_data[i] || ev_rd_idx[i] != exp_rd_idx[i])
          $display("FAIL rand%0d_rd%0d: got %h@%0d required %h@%0d", it, i, ev_rd_data[i], ev_rd_idx[i],
                   exp_rd_data[i], exp_rd_idx[i]);
        else n_pass++;
      end
      n_chk++;
      if (err !== 1'b0) $display("FAIL rand%0d_err: got %b required 0", it, err);
      else n_pass++;
    end
    m_spur = 1'b0;
  endtask

  task automatic test_busy_held();
    int sc, rel; bit ok;
    tbl_write(0, 7'h2A, 1'b0, 24'h123456, 1'b1);
    m_force = 1'b1; m_hold = 5; m_early = 1'b0;
    repeat (2) @(negedge clk);
    pulse_start(1, sc);
    repeat (20) @(negedge clk);
    #1;
    n_chk++;
    if (ev_vin_cyc.size() != 0 || running !== 1'b1)
      $display("FAIL busy_held_withhold: got vins=%0d running=%b required 0/1", ev_vin_cyc.size(), running);
    else n_pass++;
    m_force = 1'b0; rel = cyc;
    wait_done(200, ok);
    n_chk++;
    if (ev_vin_cyc.size() != 1) $display("FAIL busy_held_vin_count: got %0d required 1", ev_vin_cyc.size());
    else n_pass++;
    if (ev_vin_cyc.size() > 0) begin
      n_chk++;
      if (ev_vin_cyc[0] <= rel) $display("FAIL busy_held_order: got vin@%0d required after %0d", ev_vin_cyc[0], rel);
      else n_pass++;
    end
  endtask

  task automatic test_cnt0_and_lock();
    int sc; bit ok;
    pulse_start(0, sc);
    wait_done(20, ok);
    if (ok) begin
      n_chk++;
      if (ev_done_cyc[0] - sc != 2) $display("FAIL cnt0_delay: got %0d required 2", ev_done_cyc[0] - sc);
      else n_pass++;
    end
    n_chk++;
    if (ev_vin_cyc.size() != 0) $display("FAIL cnt0_vin: got %0d required 0", ev_vin_cyc.size());
    else n_pass++;
    tbl_write(3, 7'h33, 1'b0, 24'hC0FFEE, 1'b1);
    m_hold = 40; m_early = 1'b0;
    pulse_start(1, sc);
    repeat (3) @(negedge clk);
    n_chk++;
    if (running !== 1'b1) $display("FAIL lock_running: got %b required 1", running);
    else n_pass++;
    tbl_write(3, 7'h4C, 1'b1, 24'h3F0011, 1'b0);
    tbl_write(0, 7'h55, 1'b1, 24'h0BAD00, 1'b0);
    wait_done(300, ok);
    m_hold = 3;
    pulse_start(4, sc);
    wait_done(600, ok);
    n_chk++;
    if (ev_vin_cyc.size() != 4) $display("FAIL lock_vin_count: got %0d required 4", ev_vin_cyc.size());
    else n_pass++;
    if (ev_vin_cyc.size() == 4) begin
      n_chk++;
      if ({ev_vin_ain[3], ev_vin_din[3], ev_vin_op[3]} !== {sh_ain[3], sh_din[3], sh_op[3]} ||
          {ev_vin_ain[0], ev_vin_din[0]} !== {sh_ain[0], sh_din[0]})
        $display("FAIL lock_table: got e3=%h/%h e0=%h/%h required e3=%h/%h e0=%h/%h", ev_vin_ain[3],
                 ev_vin_din[3], ev_vin_ain[0], ev_vin_din[0], sh_ain[3], sh_din[3], sh_ain[0], sh_din[0]);
      else n_pass++;
    end
  endtask

  task automatic test_timeout();
    int v, d, nv; bit seen;
    for (int i = 0; i < 3; i++) tbl_write(i, 7'(8'h10 + i), 1'b0, 24'($urandom), 1'b1);
    busy_t = 1'b0; v = -1; d = -1; nv = 0;
    @(negedge clk); start_t = 1'b1; cnt_t = CW'(3);
    @(negedge clk); start_t = 1'b0;
    for (int i = 0; i < 300 && d < 0; i++) begin
      @(negedge clk);
      if (vin_t) begin
        nv++;
        if (v < 0) begin
          v = cyc;
          busy_t = 1'b1;
          n_chk++;
          if (ain_t !== sh_ain[0]) $display("FAIL timeout_ain: got %h required %h", ain_t, sh_ain[0]);
          else n_pass++;
        end
      end
      if (done_t) d = cyc;
    end
    n_chk++;
    if (d < 0 || v < 0 || d - v < 45 || d - v > 55)
      $display("FAIL timeout_delay: got vin@%0d done@%0d required done about 50 after vin", v, d);
    else n_pass++;
    n_chk++;
    if (err_t !== 1'b1) $display("FAIL timeout_err: got %b required 1", err_t);
    else n_pass++;
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (vin_t) seen = 1'b1;
    end
    n_chk++;
    if (nv != 1 || seen || err_t !== 1'b1)
      $display("FAIL timeout_skip: got vins=%0d late=%b err=%b required 1/0/1", nv, seen, err_t);
    else n_pass++;
    busy_t = 1'b0;
    @(negedge clk); start_t = 1'b1; cnt_t = '0;
    @(negedge clk); start_t = 1'b0;
    @(negedge clk);
    n_chk++;
    if (err_t !== 1'b0) $display("FAIL timeout_clear: got %b required 0", err_t);
    else n_pass++;
  endtask

  task automatic test_rst_mid();
    int sc; bit got;
    tbl_write(0, 7'h5B, 1'b1, 24'hA5A5A5, 1'b1);
    tbl_write(1, 7'h6D, 1'b0, 24'h5A5A5A, 1'b1);
    m_hold = 40; m_early = 1'b0;
    pulse_start(2, sc);
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk); #1;
      got = (ev_vin_cyc.size() > 0);
    end
    repeat (6) @(negedge clk);
    n_chk++;
    if (!got || running !== 1'b1 || busy !== 1'b1)
      $display("FAIL rst_mid_setup: got vin=%b running=%b busy=%b required 1/1/1", got, running, busy);
    else n_pass++;
    rst = 1'b1;
    #1;
    n_chk++;
    if ({vin, rd_valid, done, running, err} !== 5'b0)
      $display("FAIL rst_mid_flags: got %b required 00000", {vin, rd_valid, done, running, err});
    else n_pass++;
    n_chk++;
    if ({ain, din, opcode, rd_data, rd_idx} !== 60'h0)
      $display("FAIL rst_mid_data: got %h required 0", {ain, din, opcode, rd_data, rd_idx});
    else n_pass++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_logs();
    repeat (80) @(negedge clk);
    n_chk++;
    if (ev_vin_cyc.size() != 0 || running !== 1'b0)
      $display("FAIL rst_mid_quiet: got vins=%0d running=%b required 0/0", ev_vin_cyc.size(), running);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_wrw_read();
    test_random();
    test_busy_held();
    test_cnt0_and_lock();
    test_timeout();
    test_rst_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
